i2s_receiver: RTL and testbench
===============================

// Module: i2s_receiver
// PURPOSE
//  I2S slave receiver: deserialises an external I2S stream (ADC or a looped-back i2s_transmitter)
//  into parallel left/right PCM words in the clk (24.576 MHz) domain. Sits between the I2S input
//  pins and the synth sample path. Captures words MSB-first, with the data bit one bit_clock behind WS.
//  Delivers one left/right pair per frame with a single-cycle valid strobe.
// PARAMETERS
//  SAMPLE_WIDTH  16  bits captured per channel word (MSB-justified)
//  SLOT_BITS     16  expected bit_clock periods per channel slot; any other count is a frame error
// PORTS
//  clk           in   1             system clock, 24.576 MHz
//  rst           in   1             asynchronous, active-low reset
//  i2s_bclk      in   1             external bit clock, asynchronous to clk, <= clk/4
//  i2s_ws        in   1             word select: 0 = left, 1 = right; asynchronous
//  i2s_sd        in   1             serial data, MSB first; asynchronous
//  left_sample   out  SAMPLE_WIDTH  last complete left word
//  right_sample  out  SAMPLE_WIDTH  last complete right word, from the same frame as left_sample
//  sample_valid  out  1             1-clk pulse when left_sample/right_sample update
//  frame_error   out  1             1-clk pulse when a completed word's bit count != SLOT_BITS
//  locked        out  1             high once the first WS transition has been seen
// BEHAVIOUR
//  Reset: all outputs 0; synchronisers, shift register and bit counter 0; ws_prev 0; locked 0.
//  Sync: each input passes through 2 flops. A third bclk flop detects edges;
//   rise = bclk_s2 & ~bclk_s3. ws_s2 and sd_s2 are sampled only on rise (same delay, so aligned).
//  Per rise:
//   - if bit_cnt < SAMPLE_WIDTH: shift reg[SAMPLE_WIDTH-1-bit_cnt] <= sd.
//   - bit_cnt increments and saturates at 63 (6 bits); it never wraps.
//   - ws_chg = (ws_s2 != ws_prev); ws_prev <= ws_s2.
//  On a ws_chg rise:
//   - the bit sampled on that same rise is the LSB of the OLD word, captured before the word closes.
//   - the word completes; its channel is ws_prev (0 = left).
//   - bit count of the completed word = bit_cnt + 1; if != SLOT_BITS and locked, pulse frame_error.
//   - bit_cnt <= 0 and the shift reg is cleared, so the next rise lands on the MSB.
//   - locked <= 1. A word that ends while locked = 0 is discarded, and no error is raised.
//  Short words: LSBs that were not received read 0. Long words: bits beyond SAMPLE_WIDTH are ignored.
//  Left completion: the word goes to an internal left holding register; outputs are unchanged.
//  Right completion, with locked = 1 and a left word held since the last pair:
//   - left_sample <= holding register, right_sample <= new word, sample_valid = 1 for one clk.
//   - outputs hold until the next pair.
//   - a right word with no held left word (first frame after lock) is dropped, with no valid pulse.
//  Latency: sample_valid asserts 4 clk after the external bclk rising edge that carries the right-channel LSB.
//  Simultaneous events: frame_error and sample_valid may pulse in the same cycle; the sample is still delivered.
//  WS change mid-word: the word closes early (short word) and frame_error pulses.
//  Stuck bclk: no rises, outputs hold, no error. Reset mid-frame: everything returns to reset values
//   immediately; the receiver relocks on the next WS transition.
// TESTING
//  1. Reset asserted with random pin activity -> all outputs 0, locked 0, no pulses.
//  2. Loopback from i2s_transmitter (clk/32 bclk), new_sound_sample=16'hA5C3 ->
//     locked, then sample_valid once per 32 bclk with left=right=16'hA5C3 and frame_error never set.
//  3. Model sends L=16'h8001, R=16'h7FFE, then L=16'h0000, R=16'hFFFF ->
//     two valid pulses with exactly those pairs; right pulse 4 clk after the LSB bclk rise.
//  4. 24-bit slots (L=24'h123456, R=24'hABCDEF), SLOT_BITS=16 -> frame_error per word,
//     left=16'h1234, right=16'hABCD.
//  5. Stream starts mid right word -> no valid until one full left+right pair after the first WS
//     change; the first discarded words raise no frame_error.
//  6. rst pulsed low mid-left-word -> outputs 0 at once; after release, the first valid carries
//     only post-reset data.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S slave receiver: synchronises bclk/ws/sd into clk, deserialises MSB-first words and
// delivers each left/right pair from one frame with a single-cycle sample_valid strobe.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i2s_bclk,
    input  logic                    i2s_ws,
    input  logic                    i2s_sd,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    output logic                    frame_error,
    output logic                    locked
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic bclk_s1, bclk_s2, bclk_s3;
    logic ws_s1, ws_s2;
    logic sd_s1, sd_s2;

    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] word_next;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W:0]          word_bits;
    logic                    ws_prev;
    logic                    ws_seen;
    logic                    rise;
    logic                    ws_chg;

    logic                    done;
    logic [SAMPLE_WIDTH-1:0] done_word;
    logic [CNT_W:0]          done_cnt;
    logic                    done_ch;
    logic                    done_locked;

    logic [SAMPLE_WIDTH-1:0] hold_left;
    logic                    left_held;

    assign rise      = bclk_s2 & ~bclk_s3;
    // ws_prev only holds a real line level after the first rise, so a stream that starts
    // mid right word does not fake a transition against the reset value.
    assign ws_chg    = ws_seen & (ws_s2 != ws_prev);
    assign word_bits = {1'b0, bit_cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        word_next = shift_reg;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (bit_cnt == CNT_W'(SAMPLE_WIDTH - 1 - i)) begin
                word_next[i] = sd_s2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            ws_s1   <= 1'b0;
            ws_s2   <= 1'b0;
            sd_s1   <= 1'b0;
            sd_s2   <= 1'b0;
        end else begin
            bclk_s1 <= i2s_bclk;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            ws_s1   <= i2s_ws;
            ws_s2   <= ws_s1;
            sd_s1   <= i2s_sd;
            sd_s2   <= sd_s1;
        end
    end

    // Front end: shift bits in on each bclk rise and close the word on a WS change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            ws_prev     <= 1'b0;
            ws_seen     <= 1'b0;
            locked      <= 1'b0;
            done        <= 1'b0;
            done_word   <= '0;
            done_cnt    <= '0;
            done_ch     <= 1'b0;
            done_locked <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rise) begin
                ws_prev <= ws_s2;
                ws_seen <= 1'b1;
                if (ws_chg) begin
                    done        <= 1'b1;
                    done_word   <= word_next;
                    done_cnt    <= word_bits;
                    done_ch     <= ws_prev;
                    done_locked <= locked;
                    shift_reg   <= '0;
                    bit_cnt     <= '0;
                    locked      <= 1'b1;
                end else begin
                    shift_reg <= word_next;
                    if (bit_cnt != CNT_MAX) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Back end: pair a held left word with the following right word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_left    <= '0;
            left_held    <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (done && done_locked) begin
                if (done_cnt != (CNT_W + 1)'(SLOT_BITS)) begin
                    frame_error <= 1'b1;
                end
                if (!done_ch) begin
                    hold_left <= done_word;
                    left_held <= 1'b1;
                end else if (left_held) begin
                    left_sample  <= hold_left;
                    right_sample <= done_word;
                    sample_valid <= 1'b1;
                    left_held    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives I2S frames from a bit-level model and checks
// captured pairs, strobe latency, frame errors and reset behaviour.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        i2s_bclk;
    logic        i2s_ws;
    logic        i2s_sd;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        frame_error;
    logic        locked;

    i2s_receiver #(.SAMPLE_WIDTH(16), .SLOT_BITS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .i2s_bclk     (i2s_bclk),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .frame_error  (frame_error),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] v_left[$];
    logic [15:0] v_right[$];
    int          v_cyc[$];
    int          e_cyc[$];
    int          r_lsb[$];
    int          last_rise;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(negedge clk) begin
        if (sample_valid) begin
            v_left.push_back(left_sample);
            v_right.push_back(right_sample);
            v_cyc.push_back(cyc);
        end
        if (frame_error) e_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_bit(input logic ws, input logic sd, input int half);
        @(negedge clk);
        i2s_bclk = 1'b0;
        i2s_ws   = ws;
        i2s_sd   = sd;
        repeat (half - 1) @(negedge clk);
        @(negedge clk);
        i2s_bclk  = 1'b1;
        last_rise = cyc;
        repeat (half - 1) @(negedge clk);
    endtask

    // WS switches to the next channel on the LSB bit of each word.
    task automatic send_word(input logic ch, input logic [31:0] data, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            send_bit((i == n - 1) ? ~ch : ch, data[n-1-i], half);
        end
        if (ch) r_lsb.push_back(last_rise);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input int half);
        send_word(1'b0, l, n, half);
        send_word(1'b1, r, n, half);
    endtask

    task automatic clear_q();
        @(posedge clk);
        v_left.delete();
        v_right.delete();
        v_cyc.delete();
        e_cyc.delete();
        r_lsb.delete();
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_left"},  32'(left_sample),  32'h0);
        check({tag, "_right"}, 32'(right_sample), 32'h0);
        check({tag, "_valid"}, 32'(sample_valid), 32'h0);
        check({tag, "_ferr"},  32'(frame_error),  32'h0);
        check({tag, "_lock"},  32'(locked),       32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_l[2];
        logic [15:0] exp_r[2];

        // Reset with random pin activity
        rst = 1'b0;
        i2s_bclk = 1'b0;
        i2s_ws = 1'b0;
        i2s_sd = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            i2s_bclk = 1'($urandom_range(0, 1));
            i2s_ws   = 1'($urandom_range(0, 1));
            i2s_sd   = 1'($urandom_range(0, 1));
            if (i % 10 == 9) check_outputs_zero("reset_rand");
        end
        check("reset_no_valid", 32'(v_cyc.size()), 0);
        check("reset_no_ferr",  32'(e_cyc.size()), 0);
        @(negedge clk);
        i2s_bclk = 1'b0;
        i2s_ws = 1'b0;
        i2s_sd = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        clear_q();

        // Loopback-style stream at clk/32 bclk
        repeat (4) send_frame(32'hA5C3, 32'hA5C3, 16, 16);
        settle();
        check("loop_locked", 32'(locked), 1);
        check("loop_valid_cnt", 32'(v_cyc.size()), 3);
        for (int i = 0; i < v_cyc.size(); i++) begin
            check($sformatf("loop_left%0d", i),  32'(v_left[i]),  32'hA5C3);
            check($sformatf("loop_right%0d", i), 32'(v_right[i]), 32'hA5C3);
            if (i > 0) check($sformatf("loop_spacing%0d", i), 32'(v_cyc[i] - v_cyc[i-1]), 1024);
        end
        check("loop_ferr", 32'(e_cyc.size()), 0);
        clear_q();

        // Two pairs at clk/4 bclk, with strobe latency
        exp_l[0] = 16'h8001; exp_r[0] = 16'h7FFE;
        exp_l[1] = 16'h0000; exp_r[1] = 16'hFFFF;
        send_frame(32'(exp_l[0]), 32'(exp_r[0]), 16, 2);
        send_frame(32'(exp_l[1]), 32'(exp_r[1]), 16, 2);
        settle();
        check("pair_valid_cnt", 32'(v_cyc.size()), 2);
        for (int i = 0; i < v_cyc.size() && i < 2; i++) begin
            check($sformatf("pair_left%0d", i),  32'(v_left[i]),  32'(exp_l[i]));
            check($sformatf("pair_right%0d", i), 32'(v_right[i]), 32'(exp_r[i]));
            check($sformatf("pair_latency%0d", i), 32'(v_cyc[i] - r_lsb[i]), 4);
        end
        check("pair_ferr", 32'(e_cyc.size()), 0);
        clear_q();

        // 24-bit slots against SLOT_BITS=16
        send_frame(32'h123456, 32'hABCDEF, 24, 2);
        settle();
        check("long_valid_cnt", 32'(v_cyc.size()), 1);
        check("long_ferr_cnt", 32'(e_cyc.size()), 2);
        if (v_cyc.size() == 1) begin
            check("long_left",  32'(v_left[0]),  32'h1234);
            check("long_right", 32'(v_right[0]), 32'hABCD);
            if (e_cyc.size() == 2) check("long_ferr_with_valid", 32'(e_cyc[1]), 32'(v_cyc[0]));
        end

        // Stream starting mid right word
        i2s_bclk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_start_unlocked", 32'(locked), 0);
        clear_q();
        send_word(1'b1, 32'h2A, 6, 2);
        settle();
        check("mid_locked", 32'(locked), 1);
        check("mid_no_valid_tail", 32'(v_cyc.size()), 0);
        send_word(1'b0, 32'h1357, 16, 2);
        settle();
        check("mid_no_valid_left", 32'(v_cyc.size()), 0);
        send_word(1'b1, 32'h2468, 16, 2);
        settle();
        check("mid_valid_cnt", 32'(v_cyc.size()), 1);
        if (v_cyc.size() == 1) begin
            check("mid_left",  32'(v_left[0]),  32'h1357);
            check("mid_right", 32'(v_right[0]), 32'h2468);
        end
        check("mid_ferr", 32'(e_cyc.size()), 0);

        // Reset pulsed mid left word
        for (int i = 0; i < 8; i++) send_bit(1'b0, (i < 4), 2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs_zero("midrst_now");
        i2s_bclk = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("midrst_hold");
        rst = 1'b1;
        clear_q();
        send_word(1'b0, 32'hF0, 8, 2);
        send_word(1'b1, 32'hFFFF, 16, 2);
        send_frame(32'h0F1E, 32'h3C2D, 16, 2);
        settle();
        check("midrst_valid_cnt", 32'(v_cyc.size()), 1);
        if (v_cyc.size() >= 1) begin
            check("midrst_left",  32'(v_left[0]),  32'h0F1E);
            check("midrst_right", 32'(v_right[0]), 32'h3C2D);
        end
        check("midrst_ferr", 32'(e_cyc.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
